// File: rtl/f_pc_ctrl.sv
// Fetch-stage PC sequencer: owns F_PC, arbitrates next-PC / stall / exception / eret
// redirects, flags fetch address errors and keeps saturating stall statistics.
module f_pc_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
  parameter logic [31:0] IM_BASE   = 32'h0000_3000,
  parameter logic [31:0] IM_LIMIT  = 32'h0000_6ffc
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] npc,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  output logic [31:0] F_PC,
  output logic        fetch_valid,
  output logic        f_adel,
  output logic [1:0]  state,
  output logic [15:0] stall_cnt,
  output logic [15:0] stall_events
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    HOLD  = 2'd2,
    REDIR = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] evt_q, evt_d;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hffff) ? v : v + 16'd1;
  endfunction

  always_comb begin
    // NOTE: every next-state signal gets its hold value first, so no path leaves it
    // unassigned and no latch is inferred.
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    evt_d   = evt_q;
    if (exc_req) begin
      pc_d    = EXC_ENTRY;
      state_d = REDIR;
    end else if (eret_req) begin
      pc_d    = epc;
      state_d = REDIR;
    end else begin
      unique case (state_q)
        // Bubble states always fall through to RUN; stall cannot extend them.
        BOOT, REDIR: state_d = RUN;
        RUN: begin
          if (stall) begin
            state_d = HOLD;
            cnt_d   = sat_inc(cnt_q);
            evt_d   = sat_inc(evt_q);
          end else begin
            pc_d = npc;
          end
        end
        HOLD: begin
          if (stall) begin
            cnt_d = sat_inc(cnt_q);
          end else begin
            pc_d    = npc;
            state_d = RUN;
          end
        end
        default: state_d = BOOT;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
      evt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      evt_q   <= evt_d;
    end
  end

  assign F_PC         = pc_q;
  assign state        = state_q;
  assign stall_cnt    = cnt_q;
  assign stall_events = evt_q;
  assign fetch_valid  = (state_q == RUN) || (state_q == HOLD);
  assign f_adel       = fetch_valid &
                        ((pc_q[1:0] != 2'b00) || (pc_q < IM_BASE) || (pc_q > IM_LIMIT));

endmodule

// File: doc/f_pc_ctrl.md
# f_pc_ctrl

Fetch-stage PC sequencer. It owns the F-stage PC register and decides each cycle whether the PC takes the next-PC value, holds for a stall, or is redirected to the exception entry or EPC. It also flags fetch address errors and counts stall cycles and stall episodes for performance monitoring. It sits between the D-stage next-PC logic, the hazard unit, the CP0/exception logic and the instruction memory.

## Interface

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- EXC_ENTRY, 32'h0000_4180, exception handler entry address.
- IM_BASE, 32'h0000_3000, lowest legal fetch address.
- IM_LIMIT, 32'h0000_6ffc, highest legal fetch address (inclusive).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hazard-unit stall; holds the PC.
- npc  in  32  next PC from D-stage next-PC logic. Equals F_PC+4 when no control transfer is taken.
- exc_req  in  1  exception taken (from the M stage).
- eret_req  in  1  eret committing (from the M stage).
- epc  in  32  return address used for eret.
- F_PC  out  32  current fetch address to the instruction memory.
- fetch_valid  out  1  F_PC is a real fetch. Low means the F/D register captures a bubble.
- f_adel  out  1  fetch address error for the current F_PC.
- state  out  2  FSM state: BOOT=0, RUN=1, HOLD=2, REDIR=3.
- stall_cnt  out  16  stalled cycles, saturating at 16'hffff.
- stall_events  out  16  stall episodes (entries into HOLD), saturating at 16'hffff.

## Operation

- The PC source is chosen by this priority (highest first):
  - reset
  - exc_req
  - eret_req
  - BOOT exit
  - stall
  - npc
- Reset (synchronous): F_PC=RESET_PC, state=BOOT, stall_cnt=0, stall_events=0.
- BOOT: fetch_valid=0 and F_PC holds. Next state is RUN; stall is ignored.
- RUN:
  - stall=1: F_PC holds, next state HOLD, stall_events+1, stall_cnt+1.
  - stall=0: F_PC<=npc.
- HOLD:
  - stall=1: F_PC holds, stay in HOLD, stall_cnt+1.
  - stall=0: F_PC<=npc, next state RUN.
- Any state except reset, exc_req=1: F_PC<=EXC_ENTRY, next state REDIR. This overrides stall and eret_req.
- Any state except reset, eret_req=1 with exc_req=0: F_PC<=epc, next state REDIR. This overrides stall.
- REDIR: fetch_valid=0 and F_PC holds the redirect target. Next state is RUN; stall is ignored. A new exc_req or eret_req in REDIR redirects again and stays in REDIR.
- fetch_valid = 1 in RUN and HOLD, 0 in BOOT and REDIR.
- f_adel = fetch_valid & (F_PC[1:0]!=0 | F_PC<IM_BASE | F_PC>IM_LIMIT), using unsigned compares.
- f_adel does not alter sequencing. The exception logic answers it later through exc_req.
- Counters saturate and never wrap. They change only on the transitions listed above.

## Timing

- All outputs are registered except fetch_valid and f_adel, which are combinational from state and F_PC.
- Redirect latency: exc_req/eret_req sampled at edge N gives F_PC = target after edge N. The first valid fetch of the target is in the cycle after edge N+1 (one bubble cycle).
- Stall has zero latency: stall high at edge N keeps F_PC unchanged across edge N.
- Reset asserted mid-stall or mid-REDIR wins at that edge. Counters clear in the same edge.
- npc is sampled only in RUN/HOLD with stall=0. Its value is don't-care otherwise.

## Test plan

- Reset held 2 cycles, then released -> F_PC=0x3000, state BOOT with fetch_valid=0 for 1 cycle, then RUN; with npc=F_PC+4 F_PC steps 0x3000, 0x3004, 0x3008.
- In RUN at F_PC=0x3008, stall high 3 cycles -> F_PC stays 0x3008, stall_cnt=3, stall_events=1; then stall low with npc=0x3040 -> F_PC=0x3040, state RUN.
- exc_req and stall both high at F_PC=0x3010 -> F_PC=0x4180, REDIR with fetch_valid=0 for 1 cycle, then RUN fetching 0x4180.
- exc_req and eret_req both high with epc=0x3020 -> F_PC=0x4180. Then eret_req alone in REDIR -> F_PC=0x3020, REDIR for one more cycle.
- npc=0x3002 taken -> f_adel=1 while fetch_valid=1; npc=0x7000 -> f_adel=1; npc=0x6ffc -> f_adel=0.
- Stall held 70000 cycles -> stall_cnt saturates at 0xffff. Reset during that stall -> counters=0, F_PC=0x3000, state BOOT on the next cycle.
